// File: rtl/score_reader.sv
// score_reader: walks the score RAM after the game ends. Each stored
// score is shown for a fixed dwell time. While walking, the block tracks
// the highest score and the index where that score first appears.
//
// Optional build macro: SCORE_READER_BCD_EN
//   Defined: adds o_score_bcd, a three-digit BCD copy of o_cur_score
//   (hundreds in [11:8]). It is derived combinationally from the
//   registered score, so it changes together with o_score_valid.
//   This option needs DATA_W = 8.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for i_start; outputs hold the results of the last scan
// ADDR   | presents the read address and raises read enable for one cycle
// WAIT   | RAM data returns; capture score/index and update the high score
// DWELL  | hold the captured entry for DWELL_CYCLES cycles
// DONE   | one-cycle completion pulse, then back to IDLE

module score_reader #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 8,
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_num_entries,
    output logic [ADDR_W-1:0] o_rd_address,
    output logic              o_rden,
    input  logic [DATA_W-1:0] i_q,
    output logic [DATA_W-1:0] o_cur_score,
    output logic [ADDR_W-1:0] o_cur_index,
    output logic              o_score_valid,
    output logic [DATA_W-1:0] o_high_score,
    output logic [ADDR_W-1:0] o_high_index,
`ifdef SCORE_READER_BCD_EN
    output logic [11:0]       o_score_bcd,
`endif
    output logic              o_busy,
    output logic              o_done
);

    // The dwell counter only has to reach DWELL_CYCLES-1. Keep at least
    // one bit so that DWELL_CYCLES = 1 still gives a legal vector.
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ADDR_W:0]   MAX_ENTRIES = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_DWELL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_idx;
    logic [ADDR_W:0]    r_count;
    logic [CNT_W-1:0]   r_dwell_cnt;

    logic [DATA_W-1:0]  r_cur_score;
    logic [ADDR_W-1:0]  r_cur_index;
    logic               r_score_valid;
    logic [DATA_W-1:0]  r_high_score;
    logic [ADDR_W-1:0]  r_high_index;

    logic [ADDR_W:0]    w_num_clamped;
    logic [ADDR_W:0]    w_idx_plus1;
    logic               w_last_entry;
    logic               w_dwell_last;
    logic               w_accept;

    // The requested count is clamped so that the index never wraps
    // past the top of the RAM.
    assign w_num_clamped = (i_num_entries > MAX_ENTRIES) ? MAX_ENTRIES : i_num_entries;

    // The index is widened by one bit before the increment. Without this,
    // the last entry of a full RAM would wrap to zero in the comparison.
    assign w_idx_plus1  = {1'b0, r_idx} + (ADDR_W+1)'(1);
    assign w_last_entry = (w_idx_plus1 == r_count);
    assign w_dwell_last = (r_dwell_cnt == DWELL_LAST);
    assign w_accept     = (r_state == S_IDLE) && i_start;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. A start request outside IDLE is simply ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (w_num_clamped == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR:  w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_DWELL;
            S_DWELL: begin
                if (w_dwell_last) begin
                    w_state_nxt = w_last_entry ? S_DONE : S_ADDR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Scan bookkeeping: latched count, walking index and dwell timer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_dwell_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_count <= w_num_clamped;
                r_idx   <= '0;
            end

            if (r_state == S_WAIT) begin
                r_dwell_cnt <= '0;
            end else if (r_state == S_DWELL) begin
                if (w_dwell_last) begin
                    if (!w_last_entry) begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Capture the returned score and keep the running high score.
    // The comparison is strict, so a tie keeps the earlier index.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cur_score   <= '0;
            r_cur_index   <= '0;
            r_score_valid <= 1'b0;
            r_high_score  <= '0;
            r_high_index  <= '0;
        end else begin
            r_score_valid <= 1'b0;

            if (w_accept) begin
                r_high_score <= '0;
                r_high_index <= '0;
            end

            if (r_state == S_WAIT) begin
                r_cur_score   <= i_q;
                r_cur_index   <= r_idx;
                r_score_valid <= 1'b1;
                if (i_q > r_high_score) begin
                    r_high_score <= i_q;
                    r_high_index <= r_idx;
                end
            end
        end
    end

    // Every output comes straight from a register or from a decode of
    // the state register. Reset therefore clears them at once, without
    // waiting for a clock edge.
    assign o_rd_address  = r_idx;
    assign o_rden        = (r_state == S_ADDR);
    assign o_cur_score   = r_cur_score;
    assign o_cur_index   = r_cur_index;
    assign o_score_valid = r_score_valid;
    assign o_high_score  = r_high_score;
    assign o_high_index  = r_high_index;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);

`ifdef SCORE_READER_BCD_EN
    logic [3:0] w_bcd_hund;
    logic [3:0] w_bcd_tens;
    logic [3:0] w_bcd_ones;

    // Decimal digits of the displayed score. The score is registered,
    // so these digits line up with o_score_valid.
    always_comb begin
        w_bcd_hund = 4'(r_cur_score / DATA_W'(100));
        w_bcd_tens = 4'((r_cur_score / DATA_W'(10)) % DATA_W'(10));
        w_bcd_ones = 4'(r_cur_score % DATA_W'(10));
    end

    assign o_score_bcd = {w_bcd_hund, w_bcd_tens, w_bcd_ones};
`endif

endmodule

// File: tb/tb_score_reader.sv
// Testbench for score_reader with a short dwell time. The reference model
// predicts each scan from the RAM contents: one entry every DWELL+2 cycles,
// the maximum score with its first index, and done at N*(DWELL+2)+1.
module tb_score_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DWELL  = 4;
    localparam int PER    = DWELL + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num = '0;
    logic [ADDR_W-1:0] rd_address;
    logic              rden;
    logic [DATA_W-1:0] q = '0;
    logic [DATA_W-1:0] cur_score;
    logic [ADDR_W-1:0] cur_index;
    logic              score_valid;
    logic [DATA_W-1:0] high_score;
    logic [ADDR_W-1:0] high_index;
    logic              busy;
    logic              done;
`ifdef SCORE_READER_BCD_EN
    logic [11:0]       score_bcd;
`endif

    logic [7:0] ram [32];

    int errors = 0;
    int checks = 0;

    int v_idx[$];
    int v_score[$];
    int v_cyc[$];
    int v_bcd[$];
    int a_addr[$];
    int d_cyc[$];

    score_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_entries(num),
        .o_rd_address (rd_address),
        .o_rden       (rden),
        .i_q          (q),
        .o_cur_score  (cur_score),
        .o_cur_index  (cur_index),
        .o_score_valid(score_valid),
        .o_high_score (high_score),
        .o_high_index (high_index),
`ifdef SCORE_READER_BCD_EN
        .o_score_bcd  (score_bcd),
`endif
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous read RAM: data appears the cycle after the address cycle.
    always @(posedge clk) begin
        if (rden) q <= ram[rd_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a scan and records observed events for ncyc cycles after the
    // accepting edge. When disturb > 0, a start pulse and num_entries = 1
    // are applied at that cycle.
    task automatic run_scan(input int n_req, input int disturb, input int ncyc);
        v_idx.delete(); v_score.delete(); v_cyc.delete(); v_bcd.delete();
        a_addr.delete(); d_cyc.delete();
        @(negedge clk);
        start = 1'b1;
        num   = (ADDR_W+1)'(n_req);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (score_valid) begin
                v_idx.push_back(int'(cur_index));
                v_score.push_back(int'(cur_score));
                v_cyc.push_back(c);
`ifdef SCORE_READER_BCD_EN
                v_bcd.push_back(int'(score_bcd));
`endif
            end
            if (rden) a_addr.push_back(int'(rd_address));
            if (done) d_cyc.push_back(c);
            if (disturb > 0 && c == disturb) begin
                start = 1'b1;
                num   = (ADDR_W+1)'(1);
            end else if (disturb > 0 && c == disturb + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Compares the recorded scan against the values the model predicts
    // for the first n RAM entries.
    task automatic check_scan(input string name, input int n);
        int mx;
        int mi;
        int nv;
        string t;
        mx = 0;
        for (int k = 0; k < n; k++) if (int'(ram[k]) > mx) mx = int'(ram[k]);
        mi = 0;
        for (int k = n - 1; k >= 0; k--) if (int'(ram[k]) == mx) mi = k;

        chk({name, " valid_count"}, 32'(v_idx.size()), 32'(n));
        chk({name, " rden_count"}, 32'(a_addr.size()), 32'(n));
        nv = (v_idx.size() < n) ? v_idx.size() : n;
        for (int k = 0; k < nv; k++) begin
            chk($sformatf("%s idx%0d", name, k), 32'(v_idx[k]), 32'(k));
            chk($sformatf("%s score%0d", name, k), 32'(v_score[k]), 32'(ram[k]));
            chk($sformatf("%s vcyc%0d", name, k), 32'(v_cyc[k]), 32'(3 + k * PER));
`ifdef SCORE_READER_BCD_EN
            t = $sformatf("%03d", ram[k]);
            chk($sformatf("%s bcd%0d", name, k), 32'(v_bcd[k]),
                32'(((int'(t[0]) - 48) << 8) | ((int'(t[1]) - 48) << 4) | (int'(t[2]) - 48)));
`endif
        end
        for (int k = 0; k < a_addr.size() && k < n; k++)
            chk($sformatf("%s addr%0d", name, k), 32'(a_addr[k]), 32'(k));
        chk({name, " done_count"}, 32'(d_cyc.size()), 32'd1);
        if (d_cyc.size() > 0)
            chk({name, " done_cycle"}, 32'(d_cyc[0]), 32'(n * PER + 1));
        chk({name, " high_score"}, 32'(high_score), 32'(mx));
        chk({name, " high_index"}, 32'(high_index), 32'(mi));
        chk({name, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dn;
        int n;

        for (int k = 0; k < 32; k++) ram[k] = 8'($urandom_range(1, 200));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst rden", 32'(rden), 32'd0);
        chk("rst all_outputs",
            32'({rd_address, cur_score, cur_index, score_valid, high_score, high_index}), 32'd0);
        rst = 1'b0;

        // Directed scan with a tie at the maximum
        ram[0] = 8'd5; ram[1] = 8'd12; ram[2] = 8'd7; ram[3] = 8'd12;
        run_scan(4, 0, 4 * PER + 4);
        check_scan("basic", 4);

        // Zero entries
        run_scan(0, 0, 4);
        check_scan("zero", 0);

        // Start and num_entries change mid-scan are ignored
        run_scan(4, 10, 4 * PER + 4);
        check_scan("disturb", 4);

        // Asynchronous reset during the dwell of entry 2
        @(negedge clk);
        start = 1'b1;
        num   = (ADDR_W+1)'(4);
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int c = 1; c < 16; c++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("pre_rst busy", 32'(busy), 32'd1);
        chk("pre_rst cur_index", 32'(cur_index), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst busy", 32'(busy), 32'd0);
        chk("async_rst cur_score", 32'(cur_score), 32'd0);
        chk("async_rst high_score", 32'(high_score), 32'd0);
        chk("async_rst rd_address", 32'(rd_address), 32'd0);
        chk("async_rst all_outputs",
            32'({rd_address, rden, cur_score, cur_index, score_valid,
                 high_score, high_index, busy, done}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("async_rst no_done", 32'(dn), 32'd0);
        chk("async_rst idle", 32'(busy), 32'd0);

        // Randomized scans (narrow value range to provoke ties)
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 32; k++) ram[k] = 8'($urandom_range(0, 20));
            n = $urandom_range(1, 10);
            run_scan(n, 0, n * PER + 4);
            check_scan($sformatf("rand%0d", r), n);
        end

        // Full RAM of 255, no address wrap
        for (int k = 0; k < 32; k++) ram[k] = 8'd255;
        run_scan(32, 0, 32 * PER + 4);
        check_scan("full255", 32);
        if (v_idx.size() > 0)
            chk("full255 last_index", 32'(v_idx[v_idx.size() - 1]), 32'd31);

        // Requested count above the RAM size is clamped to 32
        for (int k = 0; k < 32; k++) ram[k] = 8'($urandom_range(0, 255));
        run_scan(45, 0, 32 * PER + 4);
        check_scan("clamp", 32);

`ifdef SCORE_READER_BCD_EN
        ram[0] = 8'd0; ram[1] = 8'd9; ram[2] = 8'd100; ram[3] = 8'd255;
        run_scan(4, 0, 4 * PER + 4);
        check_scan("bcd", 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_reader.md
Name: score_reader

Overview:
- Reads back the per-round scores that the game datapath writes into the score RAM, so they can be shown after the game ends.
- On a start pulse it walks RAM addresses 0 to num_entries-1. Each entry is presented on cur_score/cur_index for a fixed dwell time, for display on the HEX/VGA path.
- While walking, it tracks the running high score and the index where that score was stored.
- Sits between the score RAM read port and the end-of-game display logic, and is triggered by the top-level FSM.

Parameters:
ADDR_W, 5, RAM address width (32 entries)
DATA_W, 8, score width
DWELL_CYCLES, 50000000, cycles each entry is held on cur_score (1 s at 50 MHz); legal values are 1 and up

Ports:
clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin readback
num_entries  input  ADDR_W+1  number of valid RAM entries; latched when start is accepted
rd_address  output  ADDR_W  RAM read address
rden  output  1  RAM read enable
q  input  DATA_W  RAM read data; valid the cycle after the address cycle
cur_score  output  DATA_W  score currently displayed
cur_index  output  ADDR_W  index of cur_score
score_valid  output  1  one-cycle pulse when cur_score/cur_index update
high_score  output  DATA_W  maximum score seen in the current/last scan
high_index  output  ADDR_W  index of the first occurrence of high_score
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the scan completes

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs are 0; the internal index, dwell counter and latched count are 0.
  - Reset mid-scan aborts immediately; no done pulse is produced.
- States: IDLE, ADDR, WAIT, DWELL, DONE.
- IDLE:
  - busy=0, rden=0.
  - start=1 at a clock edge accepts the request: num_entries is latched, idx=0, high_score=0, high_index=0.
  - Next state is ADDR, or DONE if the latched count is 0.
  - cur_score and cur_index hold their previous values until the first new capture.
- ADDR (1 cycle): rd_address=idx, rden=1. Next state is WAIT.
- WAIT (1 cycle):
  - rden=0; rd_address holds idx.
  - At the closing edge: cur_score<=q, cur_index<=idx, and score_valid is 1 for the following cycle.
  - If q > high_score (strictly greater), high_score<=q and high_index<=idx. Ties keep the earlier index.
  - Next state is DWELL, with the dwell counter cleared.
- DWELL:
  - Counts DWELL_CYCLES cycles.
  - On the last cycle: if idx+1 == latched count, next state is DONE; otherwise idx<=idx+1 and next state is ADDR.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- Timing: per-entry cost is 2+DWELL_CYCLES cycles. done is high in cycle N*(2+DWELL_CYCLES)+1 after the accepting edge (cycle 1 = first ADDR).
- start while busy=1 is ignored; no queuing.
- num_entries changing during a scan has no effect (latched value is used).
- num_entries > 2^ADDR_W is clamped to 2^ADDR_W at latch time.
- N=2^ADDR_W: idx reaches 2^ADDR_W-1 and does not wrap; the scan ends there.
- cur_score, high_score and high_index hold after DONE until the next accepted start or Reset.
- The block never writes the RAM; the write-enable to the RAM stays with the game datapath.

Optional Feature:
SCORE_READER_BCD_EN:
- Defined: adds output score_bcd (12 bits, three BCD digits of cur_score, hundreds in [11:8]).
  - It updates in the same cycle as cur_score, i.e. score_valid and score_bcd are coincident.
  - Conversion is combinational or internally pipelined, but must be valid when score_valid is high.
  - Requires DATA_W=8.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- DWELL_CYCLES=4, RAM=[5,12,7,12], start with num_entries=4:
  - score_valid pulses 4 times with (0,5),(1,12),(2,7),(3,12), 6 cycles apart.
  - high_score=12, high_index=1; done pulses once in cycle 25.
- start with num_entries=0: no rden, no score_valid; done in cycle 1 after acceptance; high_score=0.
- Reset asserted asynchronously during the DWELL of entry 2:
  - All outputs go to 0 without waiting for a clock edge; no done pulse.
  - A subsequent start re-scans from index 0.
- start pulsed again mid-scan, and num_entries changed to 1 mid-scan: both ignored; the original 4-entry scan completes unchanged.
- RAM all 255 with ADDR_W=5, num_entries=32: 32 score_valid pulses, last index 31, high_score=255, high_index=0, no address wrap.
- SCORE_READER_BCD_EN defined, RAM=[0,9,100,255]: score_bcd equals 0x000, 0x009, 0x100, 0x255 coincident with each score_valid.
